sigma_soc: RTL and testbench

//  Compact debug-controlled SoC shell: a UART debug bridge (UDM-style) receives

---
 rtl/sigma_soc.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_sigma_soc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_soc.sv
// rtl/sigma_soc.sv - UART debug bridge SoC shell with word RAM, GPIO and button IRQ CSRs
module sigma_soc #(
   parameter int mem_size             = 8192,
   parameter int DEBOUNCER_FACTOR_POW = 2,
   parameter int UART_DIV             = 1302,
   parameter int SRST_CYCLES          = 16
) (
   input  logic        clk_i,
   input  logic        arst_i,
   input  logic        irq_btn_i,
   input  logic        rx_i,
   output logic        tx_o,
   input  logic [31:0] gpio_bi,
   output logic [31:0] gpio_bo
);

   localparam int AW    = $clog2(mem_size);
   localparam int WORDS = mem_size / 4;
   localparam int CW    = $clog2(UART_DIV + 1);
   localparam int RW    = $clog2(SRST_CYCLES + 1);
   localparam int DP    = DEBOUNCER_FACTOR_POW;

   localparam logic [CW-1:0] DIV_LAST  = CW'(UART_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(UART_DIV / 2 - 1);
   localparam logic [RW-1:0] SRST_END  = RW'(SRST_CYCLES);

   localparam logic [29:0] LED_W  = 30'h2000_0000;
   localparam logic [29:0] SW_W   = 30'h2000_0001;
   localparam logic [29:0] IRQ_W  = 30'h2000_0002;

   // ---------------- internal reset stretch ----------------
   logic [RW-1:0] srst_cnt;
   logic          srst;

   // counter restarts while arst_i is low and runs to SRST_END once released
   always_ff @(posedge clk_i) begin
      if (!arst_i)
         srst_cnt <= '0;
      else if (srst_cnt != SRST_END)
         srst_cnt <= srst_cnt + 1'b1;
   end

   assign srst = (srst_cnt != SRST_END);

   // ---------------- input synchronizers ----------------
   logic [1:0]  rx_sync;
   logic [1:0]  btn_sync;
   logic [31:0] gpio_s1, gpio_s2;
   logic        rx_s, btn_s;

   // two-flop synchronizers for every asynchronous input
   always_ff @(posedge clk_i) begin
      if (srst) begin
         rx_sync  <= 2'b11;
         btn_sync <= 2'b00;
         gpio_s1  <= '0;
         gpio_s2  <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], rx_i};
         btn_sync <= {btn_sync[0], irq_btn_i};
         gpio_s1  <= gpio_bi;
         gpio_s2  <= gpio_s1;
      end
   end

   assign rx_s  = rx_sync[1];
   assign btn_s = btn_sync[1];

   // ---------------- UART receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_shift, rx_shift_n;
   logic          rx_prev;
   logic          rx_valid, rx_err;

   // receiver state register; rx_prev gives the falling-edge reference
   always_ff @(posedge clk_i) begin
      if (srst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_prev  <= 1'b1;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_prev  <= rx_s;
      end
   end

   // receiver next state: half-bit start check, centre sampling, stop validation
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_valid   = 1'b0;
      rx_err     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_state_n = RX_START;
               rx_cnt_n   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == DIV_LAST) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s, rx_shift[7:1]};
               rx_bit_n   = rx_bit + 1'b1;
               if (rx_bit == 3'd7)
                  rx_state_n = RX_STOP;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == DIV_LAST) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               rx_valid   = rx_s;
               rx_err     = !rx_s;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // ---------------- UART transmitter ----------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_shift, tx_shift_n;
   logic          tx_start, tx_busy, tx_line;
   logic [7:0]    tx_byte;

   // transmitter state register
   always_ff @(posedge clk_i) begin
      if (srst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
      end
   end

   // transmitter next state: start, 8 data bits LSB first, stop
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_line    = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (tx_start) begin
               tx_shift_n = tx_byte;
               tx_cnt_n   = '0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            tx_line = 1'b0;
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = TX_DATA;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            tx_line = tx_shift[0];
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b0, tx_shift[7:1]};
               tx_bit_n   = tx_bit + 1'b1;
               if (tx_bit == 3'd7)
                  tx_state_n = TX_STOP;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n   = '0;
               tx_state_n = TX_IDLE;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   assign tx_busy = (tx_state != TX_IDLE);
   assign tx_o    = tx_line | srst;

   // ---------------- frame parser ----------------
   typedef enum logic [2:0] {P_IDLE, P_CMD, P_ADDR, P_DATA, P_EXEC, P_RESP} p_state_t;
   p_state_t    p_state, p_state_n;
   logic [7:0]  cmd, cmd_n;
   logic [31:0] addr, addr_n;
   logic [31:0] wdata, wdata_n;
   logic [1:0]  byte_cnt, byte_cnt_n;
   logic [31:0] resp_data, resp_data_n;
   logic [2:0]  resp_cnt, resp_cnt_n;
   logic        resp_load, resp_load_n;
   logic        bus_we;
   logic [31:0] bus_rdata;

   // parser state register; a reset mid-frame discards everything collected
   always_ff @(posedge clk_i) begin
      if (srst) begin
         p_state   <= P_IDLE;
         cmd       <= '0;
         addr      <= '0;
         wdata     <= '0;
         byte_cnt  <= '0;
         resp_data <= '0;
         resp_cnt  <= '0;
         resp_load <= 1'b0;
      end else begin
         p_state   <= p_state_n;
         cmd       <= cmd_n;
         addr      <= addr_n;
         wdata     <= wdata_n;
         byte_cnt  <= byte_cnt_n;
         resp_data <= resp_data_n;
         resp_cnt  <= resp_cnt_n;
         resp_load <= resp_load_n;
      end
   end

   // parser next state: collect fields little-endian, execute, stream reply bytes
   always_comb begin
      p_state_n   = p_state;
      cmd_n       = cmd;
      addr_n      = addr;
      wdata_n     = wdata;
      byte_cnt_n  = byte_cnt;
      resp_data_n = resp_data;
      resp_cnt_n  = resp_cnt;
      resp_load_n = resp_load;
      bus_we      = 1'b0;
      tx_start    = 1'b0;
      tx_byte     = resp_data[7:0];
      case (p_state)
         P_IDLE: begin
            if (rx_valid && rx_shift == 8'h55)
               p_state_n = P_CMD;
         end
         P_CMD: begin
            if (rx_err) begin
               p_state_n = P_IDLE;
            end else if (rx_valid) begin
               cmd_n      = rx_shift;
               byte_cnt_n = '0;
               case (rx_shift)
                  8'h00:        p_state_n = P_EXEC;
                  8'h80, 8'h81: p_state_n = P_ADDR;
                  default:      p_state_n = P_IDLE;
               endcase
            end
         end
         P_ADDR: begin
            if (rx_err) begin
               p_state_n = P_IDLE;
            end else if (rx_valid) begin
               addr_n     = {rx_shift, addr[31:8]};
               byte_cnt_n = byte_cnt + 1'b1;
               if (byte_cnt == 2'd3)
                  p_state_n = (cmd == 8'h81) ? P_EXEC : P_DATA;
            end
         end
         P_DATA: begin
            if (rx_err) begin
               p_state_n = P_IDLE;
            end else if (rx_valid) begin
               wdata_n    = {rx_shift, wdata[31:8]};
               byte_cnt_n = byte_cnt + 1'b1;
               if (byte_cnt == 2'd3)
                  p_state_n = P_EXEC;
            end
         end
         P_EXEC: begin
            p_state_n   = P_RESP;
            resp_load_n = 1'b0;
            case (cmd)
               8'h00: begin
                  resp_data_n = 32'h0000_0055;
                  resp_cnt_n  = 3'd1;
               end
               8'h80: begin
                  bus_we      = 1'b1;
                  resp_data_n = 32'h0000_00AA;
                  resp_cnt_n  = 3'd1;
               end
               8'h81: begin
                  resp_cnt_n  = 3'd4;
                  resp_load_n = 1'b1;
               end
               default: resp_cnt_n = 3'd0;
            endcase
         end
         P_RESP: begin
            if (resp_load) begin
               resp_data_n = bus_rdata;
               resp_load_n = 1'b0;
            end else if (!tx_busy) begin
               if (resp_cnt != 3'd0) begin
                  tx_start    = 1'b1;
                  resp_data_n = {8'h00, resp_data[31:8]};
                  resp_cnt_n  = resp_cnt - 1'b1;
               end else begin
                  p_state_n = P_IDLE;
               end
            end
         end
         default: p_state_n = P_IDLE;
      endcase
   end

   // ---------------- bus: RAM and CSRs ----------------
   logic [31:0]   ram [WORDS];
   logic [31:0]   ram_q, csr_q, led;
   logic          is_ram, rd_is_ram, irq_stat;
   logic [AW-3:0] ram_idx;
   logic          unused_ok;

   assign is_ram    = (addr[31:AW] == '0);
   assign ram_idx   = addr[AW-1:2];
   assign unused_ok = &{1'b0, addr[1:0]};

   // word RAM with one-cycle synchronous read, contents survive reset
   always_ff @(posedge clk_i) begin
      if (bus_we && is_ram)
         ram[ram_idx] <= wdata;
      ram_q <= ram[ram_idx];
   end

   // LED register drives gpio_bo directly
   always_ff @(posedge clk_i) begin
      if (srst)
         led <= '0;
      else if (bus_we && addr[31:2] == LED_W)
         led <= wdata;
   end

   assign gpio_bo = led;

   // registered read mux for CSRs and unmapped space
   always_ff @(posedge clk_i) begin
      if (srst) begin
         rd_is_ram <= 1'b0;
         csr_q     <= '0;
      end else begin
         rd_is_ram <= is_ram;
         case (addr[31:2])
            LED_W:   csr_q <= led;
            SW_W:    csr_q <= gpio_s2;
            IRQ_W:   csr_q <= {31'd0, irq_stat};
            default: csr_q <= '0;
         endcase
      end
   end

   assign bus_rdata = rd_is_ram ? ram_q : csr_q;

   // ---------------- button debouncer and IRQ status ----------------
   logic [DP-1:0] deb_cnt;
   logic          btn_last, deb, deb_rise;

   // counter restarts on every change of the synced button; state follows once stable
   always_ff @(posedge clk_i) begin
      if (srst) begin
         deb_cnt  <= '0;
         btn_last <= 1'b0;
         deb      <= 1'b0;
      end else if (btn_s != btn_last) begin
         btn_last <= btn_s;
         deb_cnt  <= '0;
      end else if (deb_cnt == '1) begin
         deb <= btn_last;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign deb_rise = (btn_s == btn_last) && (deb_cnt == '1) && btn_last && !deb;

   // sticky press flag; a new press beats a simultaneous write-1-to-clear
   always_ff @(posedge clk_i) begin
      if (srst)
         irq_stat <= 1'b0;
      else if (deb_rise)
         irq_stat <= 1'b1;
      else if (bus_we && addr[31:2] == IRQ_W && wdata[0])
         irq_stat <= 1'b0;
   end

endmodule

// File: tb/tb_sigma_soc.sv
// tb/tb_sigma_soc.sv - randomized self-checking bench for sigma_soc against a behavioural model
module tb_sigma_soc;

   localparam int DIV = 16;
   localparam int MEM = 8192;

   logic        clk = 1'b0;
   logic        arst, btn, rx, tx;
   logic [31:0] gpio_bi, gpio_bo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rxq[$];

   always #5 clk = ~clk;

   sigma_soc #(
      .mem_size(MEM), .DEBOUNCER_FACTOR_POW(2), .UART_DIV(DIV), .SRST_CYCLES(16)
   ) dut (
      .clk_i(clk), .arst_i(arst), .irq_btn_i(btn), .rx_i(rx), .tx_o(tx),
      .gpio_bi(gpio_bi), .gpio_bo(gpio_bo)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // serial monitor on tx: decodes 8N1 bytes into rxq
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = tx;
            end
            repeat (DIV) @(negedge clk);
            rxq.push_back(b);
         end
         prev = tx;
      end
   end

   initial begin : watchdog
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_bit;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   function automatic logic [7:0] pop_byte();
      if (rxq.size() == 0) return 8'hxx;
      return rxq.pop_front();
   endfunction

   task automatic wait_bytes(input int n, input string tag);
      int k = 0;
      int budget = 12 * DIV * n + 4 * DIV;
      while (rxq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_count"}, 32'(rxq.size()), 32'(n));
   endtask

   task automatic do_check(input string tag);
      send_byte(8'h55, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_bytes(1, tag);
      check_eq(tag, {24'd0, pop_byte()}, 32'h55);
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input string tag);
      send_byte(8'h55, 1'b1);
      send_byte(8'h80, 1'b1);
      send_word(a);
      send_word(d);
      wait_bytes(1, tag);
      check_eq({tag, "_ack"}, {24'd0, pop_byte()}, 32'hAA);
   endtask

   task automatic do_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      send_byte(8'h55, 1'b1);
      send_byte(8'h81, 1'b1);
      send_word(a);
      wait_bytes(4, tag);
      for (int i = 0; i < 4; i++) d[8*i +: 8] = pop_byte();
      check_eq(tag, d, exp);
   endtask

   logic [31:0] mem_model [int];
   int          written[$];
   logic [31:0] led_model;

   initial begin : main
      logic [31:0] a, d;
      int          op, k;

      arst = 1'b0; rx = 1'b1; btn = 1'b0; gpio_bi = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_tx", {31'd0, tx}, 32'd1);
      check_eq("reset_gpio_bo", gpio_bo, 32'd0);
      arst = 1'b1;
      repeat (15) @(negedge clk);
      check_eq("srst_held", {31'd0, dut.srst}, 32'd1);
      check_eq("srst_gpio_bo", gpio_bo, 32'd0);
      @(negedge clk);
      check_eq("srst_released", {31'd0, dut.srst}, 32'd0);
      repeat (4) @(negedge clk);

      do_check("check_cmd");

      do_wr(32'h8000_0000, 32'hdead_beef, "wr_led");
      check_eq("led_out", gpio_bo, 32'hdead_beef);
      led_model = 32'hdead_beef;
      gpio_bi = 32'h30;
      repeat (4) @(negedge clk);
      do_rd(32'h8000_0004, 32'h30, "rd_sw");

      do_wr(32'h0000_1FFC, 32'h1234_5678, "wr_ram_top");
      mem_model[32'h1FFC >> 2] = 32'h1234_5678;
      written.push_back(32'h1FFC >> 2);
      do_rd(32'h0000_1FFC, 32'h1234_5678, "rd_ram_top");
      do_rd(32'h4000_0000, 32'h0, "rd_unmapped");

      btn = 1'b1; repeat (2) @(negedge clk); btn = 1'b0;
      repeat (10) @(negedge clk);
      do_rd(32'h8000_0008, 32'h0, "irq_short_pulse");
      btn = 1'b1; repeat (8) @(negedge clk); btn = 1'b0;
      repeat (10) @(negedge clk);
      do_rd(32'h8000_0008, 32'h1, "irq_held");
      do_wr(32'h8000_0008, 32'h1, "irq_clear");
      do_rd(32'h8000_0008, 32'h0, "irq_after_clear");

      send_byte(8'h55, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (4) @(negedge clk);
      do_check("bad_stop_then_check");
      repeat (30 * DIV) @(negedge clk);
      check_eq("bad_stop_extra_bytes", 32'(rxq.size()), 32'd0);

      send_byte(8'h55, 1'b1);
      send_byte(8'h00, 1'b1);
      k = 0;
      while (tx !== 1'b0 && k < 4 * DIV) begin
         @(negedge clk);
         k++;
      end
      check_eq("reply_started", {31'd0, tx}, 32'd0);
      arst = 1'b0;
      @(posedge clk); #1;
      check_eq("midframe_tx_forced", {31'd0, tx}, 32'd1);
      repeat (3) @(negedge clk);
      arst = 1'b1;
      repeat (14 * DIV) @(negedge clk);
      rxq.delete();
      check_eq("midframe_led_cleared", gpio_bo, 32'd0);
      led_model = 32'd0;
      do_check("check_after_reset");

      for (int it = 0; it < 14; it++) begin
         op = $urandom_range(0, 4);
         if (op == 1 && written.size() == 0) op = 0;
         case (op)
            0: begin
               a = ($urandom_range(0, MEM / 4 - 1) * 4) | $urandom_range(0, 3);
               d = $urandom;
               do_wr(a, d, "rnd_wr_ram");
               if (!mem_model.exists(a >> 2)) written.push_back(a >> 2);
               mem_model[a >> 2] = d;
            end
            1: begin
               k = written[$urandom_range(0, written.size() - 1)];
               do_rd(k * 4, mem_model[k], "rnd_rd_ram");
            end
            2: begin
               a = ($urandom_range(1, 7) << 28) | ($urandom & 32'h0FFF_FFFF);
               do_rd(a, 32'h0, "rnd_rd_unmapped");
            end
            3: begin
               d = $urandom;
               do_wr(32'h8000_0000, d, "rnd_wr_led");
               led_model = d;
               check_eq("rnd_led_out", gpio_bo, led_model);
               do_rd(32'h8000_0000, led_model, "rnd_rd_led");
            end
            default: begin
               gpio_bi = $urandom;
               repeat (4) @(negedge clk);
               do_rd(32'h8000_0004, gpio_bi, "rnd_rd_sw");
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
